// File: rtl/ucsbece154_icache_pf.sv
// ucsbece154_icache_pf
// Set-associative instruction cache with early restart, round-robin or LFSR
// replacement, invalidate-all flush and saturating hit/miss counters.
//
// Ports
//   Clk, ResetN                  clock, synchronous active-low reset
//   ReadEnable, ReadAddress      fetch request and byte address ([1:0] ignored)
//   Instruction, Ready, Busy     fetched word, one-cycle strobe, refill/flush active
//   Flush                        invalidate-all request
//   MemReadAddress/Request       block-aligned refill address and request level
//   MemDataIn, MemDataReady      refill word stream, words 0..BLOCK_WORDS-1 in order
//   HitCount, MissCount          saturating performance counters
//
// state  | meaning
// IDLE   | accepting fetches; hits answered next edge, misses start a refill
// FILL   | refill in progress; once MemReadRequest drops, one settling cycle
// FLUSH  | clearing valid bits, one set per cycle, set 0 first
module ucsbece154_icache_pf #(
    parameter int NUM_SETS       = 8,
    parameter int NUM_WAYS       = 4,
    parameter int BLOCK_WORDS    = 4,
    parameter int REPLACE_POLICY = 0
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    output logic [31:0] Instruction,
    output logic        Ready,
    output logic        Busy,
    input  logic        Flush,
    output logic [31:0] MemReadAddress,
    output logic        MemReadRequest,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
);
    localparam int WOFF_W = $clog2(BLOCK_WORDS);
    localparam int OFF    = 2 + WOFF_W;
    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int TAG_W  = 32 - OFF - SET_W;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH} state_t;

    logic [31:0]      data_mem [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [TAG_W-1:0] tag_mem  [NUM_SETS][NUM_WAYS];

    state_t               state_q, state_d;
    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]  valid_d [NUM_SETS];
    logic [WAY_W-1:0]     rr_q [NUM_SETS];
    logic [WAY_W-1:0]     rr_d [NUM_SETS];
    logic [15:0]          lfsr_q, lfsr_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic [31:0]          instr_q, instr_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic                 mem_req_q, mem_req_d;
    logic [31:0]          hit_cnt_q, hit_cnt_d;
    logic [31:0]          miss_cnt_q, miss_cnt_d;
    logic [SET_W-1:0]     fill_set_q, fill_set_d;
    logic [TAG_W-1:0]     fill_tag_q, fill_tag_d;
    logic [WOFF_W-1:0]    fill_off_q, fill_off_d;
    logic [WAY_W-1:0]     fill_way_q, fill_way_d;
    logic                 fill_repl_q, fill_repl_d;
    logic [WOFF_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [SET_W-1:0]     flush_idx_q, flush_idx_d;

    logic [WOFF_W-1:0] req_off;
    logic [SET_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  victim;
    logic              data_we;
    logic              tag_we;
    logic              unused_addr_bits;

    assign req_off = ReadAddress[OFF-1:2];
    assign req_set = ReadAddress[OFF+SET_W-1:OFF];
    assign req_tag = ReadAddress[31:OFF+SET_W];
    assign unused_addr_bits = ^ReadAddress[1:0];

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        victim    = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[req_set][w] && (tag_mem[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[req_set][w]) begin
                inv_found = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        if (!inv_found) begin
            victim = (REPLACE_POLICY == 1) ? lfsr_q[WAY_W-1:0] : rr_q[req_set];
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        rr_d         = rr_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        busy_d       = busy_q;
        ready_d      = 1'b0;
        instr_d      = instr_q;
        mem_addr_d   = mem_addr_q;
        mem_req_d    = mem_req_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        fill_set_d   = fill_set_q;
        fill_tag_d   = fill_tag_q;
        fill_off_d   = fill_off_q;
        fill_way_d   = fill_way_q;
        fill_repl_d  = fill_repl_q;
        fill_cnt_d   = fill_cnt_q;
        flush_pend_d = flush_pend_q;
        flush_idx_d  = flush_idx_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Flush) begin
                    state_d     = S_FLUSH;
                    busy_d      = 1'b1;
                    flush_idx_d = '0;
                end else if (ReadEnable) begin
                    if (hit) begin
                        ready_d   = 1'b1;
                        instr_d   = data_mem[req_set][hit_way][req_off];
                        hit_cnt_d = (hit_cnt_q == 32'hFFFF_FFFF) ? hit_cnt_q : hit_cnt_q + 32'd1;
                    end else begin
                        state_d     = S_FILL;
                        busy_d      = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {ReadAddress[31:OFF], {OFF{1'b0}}};
                        fill_set_d  = req_set;
                        fill_tag_d  = req_tag;
                        fill_off_d  = req_off;
                        fill_way_d  = victim;
                        fill_repl_d = !inv_found;
                        fill_cnt_d  = '0;
                        miss_cnt_d  = (miss_cnt_q == 32'hFFFF_FFFF) ? miss_cnt_q : miss_cnt_q + 32'd1;
                    end
                end
            end
            S_FILL: begin
                if (Flush) flush_pend_d = 1'b1;
                if (mem_req_q) begin
                    if (MemDataReady) begin
                        data_we = 1'b1;
                        if (fill_cnt_q == fill_off_q) begin
                            ready_d = 1'b1;
                            instr_d = MemDataIn;
                        end
                        if (fill_cnt_q == WOFF_W'(BLOCK_WORDS - 1)) begin
                            mem_req_d                     = 1'b0;
                            tag_we                        = 1'b1;
                            valid_d[fill_set_q][fill_way_q] = 1'b1;
                            // Pointer moves only when a live line was evicted.
                            if (fill_repl_q && (REPLACE_POLICY == 0)) begin
                                rr_d[fill_set_q] = rr_q[fill_set_q] + WAY_W'(1);
                            end
                        end else begin
                            fill_cnt_d = fill_cnt_q + WOFF_W'(1);
                        end
                    end
                end else begin
                    // Settling cycle after the last word: hand off to a
                    // pending flush without dropping Busy.
                    if (flush_pend_q || Flush) begin
                        state_d      = S_FLUSH;
                        flush_pend_d = 1'b0;
                        flush_idx_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                if (Flush) flush_pend_d = 1'b1;
                valid_d[flush_idx_q] = '0;
                if (flush_idx_q == SET_W'(NUM_SETS - 1)) begin
                    if (flush_pend_q || Flush) begin
                        flush_pend_d = 1'b0;
                        flush_idx_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    flush_idx_d = flush_idx_q + SET_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_q      <= S_IDLE;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            lfsr_q       <= 16'h0001;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            instr_q      <= '0;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            fill_set_q   <= '0;
            fill_tag_q   <= '0;
            fill_off_q   <= '0;
            fill_way_q   <= '0;
            fill_repl_q  <= 1'b0;
            fill_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            flush_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            rr_q         <= rr_d;
            lfsr_q       <= lfsr_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            instr_q      <= instr_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            fill_set_q   <= fill_set_d;
            fill_tag_q   <= fill_tag_d;
            fill_off_q   <= fill_off_d;
            fill_way_q   <= fill_way_d;
            fill_repl_q  <= fill_repl_d;
            fill_cnt_q   <= fill_cnt_d;
            flush_pend_q <= flush_pend_d;
            flush_idx_q  <= flush_idx_d;
        end
    end

    // Line storage has no reset; valid bits alone decide what is live.
    always_ff @(posedge Clk) begin
        if (ResetN && data_we) data_mem[fill_set_q][fill_way_q][fill_cnt_q] <= MemDataIn;
        if (ResetN && tag_we)  tag_mem[fill_set_q][fill_way_q] <= fill_tag_q;
    end

    assign Instruction    = instr_q;
    assign Ready          = ready_q;
    assign Busy           = busy_q;
    assign MemReadAddress = mem_addr_q;
    assign MemReadRequest = mem_req_q;
    assign HitCount       = hit_cnt_q;
    assign MissCount      = miss_cnt_q;
endmodule

// File: tb/tb_ucsbece154_icache_pf.sv
module tb_ucsbece154_icache_pf;
    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        ReadEnable = 1'b0;
    logic [31:0] ReadAddress = '0;
    logic [31:0] Instruction;
    logic        Ready;
    logic        Busy;
    logic        Flush = 1'b0;
    logic [31:0] MemReadAddress;
    logic        MemReadRequest;
    logic [31:0] MemDataIn = '0;
    logic        MemDataReady = 1'b0;
    logic [31:0] HitCount;
    logic [31:0] MissCount;

    int total = 0;
    int bad = 0;
    int exp_hits = 0;
    int exp_miss = 0;
    logic [31:0] exp_q[$];

    ucsbece154_icache_pf #(
        .NUM_SETS(8), .NUM_WAYS(4), .BLOCK_WORDS(4), .REPLACE_POLICY(0)
    ) dut (
        .Clk(Clk), .ResetN(ResetN),
        .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
        .Instruction(Instruction), .Ready(Ready), .Busy(Busy),
        .Flush(Flush),
        .MemReadAddress(MemReadAddress), .MemReadRequest(MemReadRequest),
        .MemDataIn(MemDataIn), .MemDataReady(MemDataReady),
        .HitCount(HitCount), .MissCount(MissCount)
    );

    always #5 Clk = ~Clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every Ready strobe must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (Ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ready: got %h expected no strobe", Instruction);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (Instruction !== e) begin
                    bad++;
                    $display("FAIL ready_word: got %h expected %h", Instruction, e);
                end
            end
        end
    end

    task automatic hit_read(input logic [31:0] addr, input logic [31:0] word);
        exp_q.push_back(word);
        exp_hits++;
        ReadEnable  = 1'b1;
        ReadAddress = addr;
        @(negedge Clk);
        ReadEnable = 1'b0;
    endtask

    // Issues a missing read and plays the memory side. flush_at / reset_at
    // name the data-word index alongside which Flush / reset is driven (-1: none).
    task automatic miss_read(input logic [31:0] addr, input logic [31:0] base,
                             input int flush_at, input int reset_at);
        logic [31:0] blk;
        int off;
        blk = {addr[31:4], 4'h0};
        off = int'(addr[3:2]);
        if (reset_at < 0 || off < reset_at) exp_q.push_back(base + 32'(off));
        exp_miss++;
        ReadEnable  = 1'b1;
        ReadAddress = addr;
        @(negedge Clk);
        ReadEnable = 1'b0;
        check32("mem_req_rise", {31'b0, MemReadRequest}, 32'd1);
        check32("mem_addr", MemReadAddress, blk);
        check32("busy_fill", {31'b0, Busy}, 32'd1);
        for (int w = 0; w < 4; w++) begin
            if (w == reset_at) begin
                ResetN       = 1'b0;
                MemDataReady = 1'b1;
                MemDataIn    = base + 32'(w);
                @(negedge Clk);
                check32("reset_mem_req", {31'b0, MemReadRequest}, 32'd0);
                check32("reset_busy", {31'b0, Busy}, 32'd0);
                ResetN   = 1'b1;
                exp_hits = 0;
                exp_miss = 0;
                @(negedge Clk);
                @(negedge Clk);
                MemDataReady = 1'b0;
                check32("stray_data_req", {31'b0, MemReadRequest}, 32'd0);
                check32("stray_data_busy", {31'b0, Busy}, 32'd0);
                return;
            end
            MemDataReady = 1'b1;
            MemDataIn    = base + 32'(w);
            Flush        = (w == flush_at);
            @(negedge Clk);
            Flush = 1'b0;
        end
        MemDataReady = 1'b0;
        check32("mem_req_drop", {31'b0, MemReadRequest}, 32'd0);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 60) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic check_counters(input string tag);
        check32({tag, "_hits"}, HitCount, 32'(exp_hits));
        check32({tag, "_miss"}, MissCount, 32'(exp_miss));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(negedge Clk);
        check32("rst_ready", {31'b0, Ready}, 32'd0);
        check32("rst_busy", {31'b0, Busy}, 32'd0);
        check32("rst_mem_req", {31'b0, MemReadRequest}, 32'd0);
        check32("rst_mem_addr", MemReadAddress, 32'd0);
        check32("rst_instr", Instruction, 32'd0);
        check_counters("rst");
        ResetN = 1'b1;
        @(negedge Clk);

        // Cold miss with early restart on word 2.
        miss_read(32'h0000_1008, 32'h0000_00A0, -1, -1);
        busy_len(n);
        check32("cold_busy_tail", 32'(n), 32'd1);
        check_counters("cold");

        // Back-to-back hits.
        hit_read(32'h0000_1000, 32'h0000_00A0);
        hit_read(32'h0000_1004, 32'h0000_00A1);
        hit_read(32'h0000_100C, 32'h0000_00A3);
        @(negedge Clk);
        check32("hits_no_req", {31'b0, MemReadRequest}, 32'd0);
        check_counters("hits");

        // Flush together with a would-be hit: flush wins, reads held during
        // Busy are ignored.
        Flush       = 1'b1;
        ReadEnable  = 1'b1;
        ReadAddress = 32'h0000_1000;
        @(negedge Clk);
        Flush = 1'b0;
        busy_len(n);
        ReadEnable = 1'b0;
        check32("flush_busy_len", 32'(n), 32'd8);
        check_counters("flush");
        miss_read(32'h0000_1008, 32'h0000_00B0, -1, -1);
        busy_len(n);
        check32("reflll_busy_tail", 32'(n), 32'd1);
        check_counters("after_flush");

        // Flush during fill: fill completes, then 8 more busy cycles.
        miss_read(32'h0000_2010, 32'h0000_00C0, 1, -1);
        busy_len(n);
        check32("fill_flush_busy", 32'(n), 32'd9);
        check_counters("fill_flush");

        // Round-robin conflict in set 0.
        miss_read(32'h0000_0000, 32'h0000_0100, -1, -1); busy_len(n);
        miss_read(32'h0000_0080, 32'h0000_0200, -1, -1); busy_len(n);
        miss_read(32'h0000_0100, 32'h0000_0300, -1, -1); busy_len(n);
        miss_read(32'h0000_0180, 32'h0000_0400, -1, -1); busy_len(n);
        miss_read(32'h0000_0200, 32'h0000_0500, -1, -1); busy_len(n);
        hit_read(32'h0000_0080, 32'h0000_0200);
        hit_read(32'h0000_0184, 32'h0000_0401);
        @(negedge Clk);
        check_counters("rr_hits");
        miss_read(32'h0000_0000, 32'h0000_0600, -1, -1);
        busy_len(n);
        check32("rr_busy_tail", 32'(n), 32'd1);
        check_counters("rr_miss");

        // Reset during a fill, then a fresh cold miss.
        miss_read(32'h0000_1008, 32'h0000_00D0, -1, 2);
        check_counters("post_reset");
        miss_read(32'h0000_1008, 32'h0000_00E0, -1, -1);
        busy_len(n);
        check_counters("post_reset_miss");

        repeat (3) @(negedge Clk);
        check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
